// File: rtl/fft_frame_tx.sv
// -----------------------------------------------------------------------------
// fft_frame_tx
//
// Frame transmitter that feeds the FFT top-level serial input. Samples arrive
// under a valid/ready handshake and are written into one of two frame banks
// (ping-pong). Every completed bank is replayed as one unbroken burst of
// FFT_LEN cycles with val_o high throughout, followed by at least GAP_CYC idle
// cycles before the next burst.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   s_val / s_rdy  upstream handshake (s_rdy is combinational from registers)
//   s_re / s_im    upstream complex sample, DATA_WID bits per component
//   val_o          burst valid (FFT val_i)
//   fft_data_re_o  real sample out (registered)
//   fft_data_im_o  imaginary sample out (registered)
//   sof_o / eof_o  first / last sample of each burst
//   frame_cnt_o    bursts completed, wraps at 16 bits
//
// Build option:
//   FFT_TX_BITREV_EN  when defined, the read address is bit-reversed over
//                     LOG2_FFT_LEN bits so bursts leave in bit-reversed order.
//                     Write order, latency and handshake are unchanged.
// -----------------------------------------------------------------------------
module fft_frame_tx #(
    parameter int DATA_WID     = 16,
    parameter int FFT_LEN      = 32,
    parameter int LOG2_FFT_LEN = 5,
    parameter int GAP_CYC      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_val,
    output logic                s_rdy,
    input  logic [DATA_WID-1:0] s_re,
    input  logic [DATA_WID-1:0] s_im,
    output logic                val_o,
    output logic [DATA_WID-1:0] fft_data_re_o,
    output logic [DATA_WID-1:0] fft_data_im_o,
    output logic                sof_o,
    output logic                eof_o,
    output logic [15:0]         frame_cnt_o
);

    localparam logic [LOG2_FFT_LEN-1:0] ADDR_LAST = LOG2_FFT_LEN'(FFT_LEN - 1);
    localparam int                      GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]        GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Maps the sequential read counter onto the bank address.
    function automatic logic [LOG2_FFT_LEN-1:0] rd_map(input logic [LOG2_FFT_LEN-1:0] a);
        logic [LOG2_FFT_LEN-1:0] r;
`ifdef FFT_TX_BITREV_EN
        for (int i = 0; i < LOG2_FFT_LEN; i++) begin
            r[i] = a[LOG2_FFT_LEN-1-i];
        end
`else
        r = a;
`endif
        return r;
    endfunction

    logic [2*DATA_WID-1:0]   mem_q [2][FFT_LEN];

    state_t                  state_q, state_d;
    logic [1:0]              full_q, full_d;
    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [LOG2_FFT_LEN-1:0] wr_addr_q, wr_addr_d;
    logic [LOG2_FFT_LEN-1:0] rd_addr_q, rd_addr_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    val_q, val_d;
    logic                    sof_q, sof_d;
    logic                    eof_q, eof_d;
    logic [DATA_WID-1:0]     re_q, re_d;
    logic [DATA_WID-1:0]     im_q, im_d;

    logic                    wr_fire;
    logic                    start;
    logic                    last;
    logic [2*DATA_WID-1:0]   rd_word;

    assign s_rdy   = !full_q[wr_bank_q];
    assign wr_fire = s_val && s_rdy;
    assign start   = (state_q == ST_IDLE) && full_q[rd_bank_q];
    assign last    = (state_q == ST_SEND) && (rd_addr_q == ADDR_LAST);
    // rd_addr_q wraps back to 0 at the end of every burst, so it is already 0
    // whenever the FSM sits in IDLE and the first word can be read directly.
    assign rd_word = mem_q[rd_bank_q][rd_map(rd_addr_q)];

    // Frame storage has no reset: contents are only read once a bank is full.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr_q] <= {s_re, s_im};
        end
    end

    // Read FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (full_q[rd_bank_q]) state_d = ST_SEND;
            ST_SEND: if (last) state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM: output logic. The output registers are loaded on the edge
    // that leaves IDLE, so the first sample appears one cycle after full is
    // seen. rd_bank toggles on the edge that loads the last sample, which lets
    // IDLE look at the other bank while eof_o is showing and start the next
    // burst back-to-back.
    always_comb begin
        val_d       = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        re_d        = '0;
        im_d        = '0;
        rd_addr_d   = rd_addr_q;
        rd_bank_d   = rd_bank_q;
        gap_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    val_d        = 1'b1;
                    sof_d        = 1'b1;
                    {re_d, im_d} = rd_word;
                    rd_addr_d    = rd_addr_q + 1'b1;
                end
            end
            ST_SEND: begin
                val_d        = 1'b1;
                {re_d, im_d} = rd_word;
                rd_addr_d    = rd_addr_q + 1'b1;
                if (last) begin
                    eof_d     = 1'b1;
                    rd_bank_d = !rd_bank_q;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: ;
        endcase
        // A burst counts as completed once its last sample is on the outputs.
        if (eof_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Write side and bank flags.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == ADDR_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_addr_d         = '0;
            end
        end
        // The bank just replayed is released after its last sample has been
        // presented; rd_bank_q already points at the next bank by then. The
        // writer can only be filling a non-full bank, so the set above never
        // targets the bank being released here.
        if (eof_q) begin
            full_d[!rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            val_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            re_q        <= '0;
            im_q        <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            val_q       <= val_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            re_q        <= re_d;
            im_q        <= im_d;
        end
    end

    assign val_o         = val_q;
    assign sof_o         = sof_q;
    assign eof_o         = eof_q;
    assign fft_data_re_o = re_q;
    assign fft_data_im_o = im_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_tx
//
// Directed bench for fft_frame_tx. Two instances share the clock: dut_a with
// GAP_CYC=32 and dut_b with GAP_CYC=0. A negedge monitor per instance records
// every val_o cycle (data, sof, eof, cycle number); each test compares the
// recorded bursts with hand-derived expectations. Sample k is sent as
// re=base+k, im=-(base+k).
// -----------------------------------------------------------------------------
module tb_fft_frame_tx;

    typedef struct {
        int re;
        int im;
        bit sof;
        bit eof;
        int cyc;
    } smp_t;

    logic        clk;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        a_rst, a_sval, a_srdy, a_valo, a_sof, a_eof;
    logic [15:0] a_re, a_im, a_reo, a_imo, a_fcnt;
    logic        b_rst, b_sval, b_srdy, b_valo, b_sof, b_eof;
    logic [15:0] b_re, b_im, b_reo, b_imo, b_fcnt;

    smp_t        a_q[$];
    smp_t        b_q[$];
    smp_t        ma, mb;

    fft_frame_tx #(.DATA_WID(16), .FFT_LEN(32), .LOG2_FFT_LEN(5), .GAP_CYC(32)) dut_a (
        .clk(clk), .rst(a_rst), .s_val(a_sval), .s_rdy(a_srdy), .s_re(a_re), .s_im(a_im),
        .val_o(a_valo), .fft_data_re_o(a_reo), .fft_data_im_o(a_imo),
        .sof_o(a_sof), .eof_o(a_eof), .frame_cnt_o(a_fcnt)
    );

    fft_frame_tx #(.DATA_WID(16), .FFT_LEN(32), .LOG2_FFT_LEN(5), .GAP_CYC(0)) dut_b (
        .clk(clk), .rst(b_rst), .s_val(b_sval), .s_rdy(b_srdy), .s_re(b_re), .s_im(b_im),
        .val_o(b_valo), .fft_data_re_o(b_reo), .fft_data_im_o(b_imo),
        .sof_o(b_sof), .eof_o(b_eof), .frame_cnt_o(b_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_valo === 1'b1) begin
            ma.re  = int'($signed(a_reo));
            ma.im  = int'($signed(a_imo));
            ma.sof = a_sof;
            ma.eof = a_eof;
            ma.cyc = cyc;
            a_q.push_back(ma);
        end
        if (b_valo === 1'b1) begin
            mb.re  = int'($signed(b_reo));
            mb.im  = int'($signed(b_imo));
            mb.sof = b_sof;
            mb.eof = b_eof;
            mb.cyc = cyc;
            b_q.push_back(mb);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Burst position j carries input sample exp_idx(j) of its frame.
    function automatic int exp_idx(input int j);
`ifdef FFT_TX_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) begin
            if (j[b]) r = r | (1 << (4 - b));
        end
        return r;
`else
        return j;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input bit sel);
        if (sel) begin b_rst = 1'b1; b_sval = 1'b0; end
        else     begin a_rst = 1'b1; a_sval = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        if (sel) b_rst = 1'b0;
        else     a_rst = 1'b0;
    endtask

    // Offers n samples, holding each until accepted. sparse drives s_val
    // 1,0,1,0,... Returns the cycle of the last acceptance, how many samples
    // had been accepted when s_rdy first fell, and the cycle it rose again.
    task automatic push(input bit sel, input int n, input int base, input bit sparse,
                        output int t_last, output int drop_k, output int rise_cyc);
        int   k;
        int   budget;
        bit   phase;
        logic v;
        logic rdy;
        k = 0; budget = 0; phase = 1'b0;
        t_last = -1; drop_k = -1; rise_cyc = -1;
        while (k < n && budget < 2000) begin
            v = !sparse || !phase;
            if (sel) begin
                b_sval = v; b_re = 16'(base + k); b_im = 16'(-(base + k));
            end else begin
                a_sval = v; a_re = 16'(base + k); a_im = 16'(-(base + k));
            end
            @(negedge clk);
            rdy = sel ? b_srdy : a_srdy;
            if (!rdy && drop_k < 0) drop_k = k;
            if (rdy && drop_k >= 0 && rise_cyc < 0) rise_cyc = cyc;
            if (v && rdy) begin
                t_last = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            phase = !phase;
            budget++;
        end
        if (sel) b_sval = 1'b0;
        else     a_sval = 1'b0;
        check("push_accepted", k, n);
    endtask

    // Checks the 32 recorded samples starting at queue index start.
    task automatic check_burst(input bit sel, input string tag, input int start,
                               input int base, input int first_cyc);
        smp_t q[$];
        smp_t s;
        if (sel) q = b_q;
        else     q = a_q;
        if (q.size() < start + 32) begin
            check({tag, "_len"}, q.size(), start + 32);
            return;
        end
        for (int j = 0; j < 32; j++) begin
            s = q[start + j];
            check($sformatf("%s_re%0d", tag, j), s.re, base + exp_idx(j));
            check($sformatf("%s_im%0d", tag, j), s.im, -(base + exp_idx(j)));
            check($sformatf("%s_sof%0d", tag, j), s.sof, (j == 0));
            check($sformatf("%s_eof%0d", tag, j), s.eof, (j == 31));
            if (j > 0) check($sformatf("%s_cont%0d", tag, j), s.cyc, q[start].cyc + j);
        end
        if (first_cyc >= 0) check({tag, "_latency"}, q[start].cyc, first_cyc);
    endtask

    initial begin
        int tl, dk, rc, cnt, budget;
        a_rst = 1'b1; a_sval = 1'b0; a_re = '0; a_im = '0;
        b_rst = 1'b1; b_sval = 1'b0; b_re = '0; b_im = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_rdy", a_srdy, 1);
        check("rst_val_o", a_valo, 0);
        check("rst_re", a_reo, 0);
        check("rst_im", a_imo, 0);
        check("rst_sof", a_sof, 0);
        check("rst_eof", a_eof, 0);
        check("rst_frame_cnt", a_fcnt, 0);
        check("rst_b_s_rdy", b_srdy, 1);
        check("rst_b_val_o", b_valo, 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // Single frame, GAP_CYC=32.
        a_q.delete();
        push(1'b0, 32, 0, 1'b0, tl, dk, rc);
        wait_cyc(40);
        check("t1_count", a_q.size(), 32);
        check_burst(1'b0, "t1", 0, 0, tl + 2);
        check("t1_frame_cnt", a_fcnt, 1);

        // Backpressure: 96 samples pushed continuously, GAP_CYC=32.
        reset_dut(1'b0);
        a_q.delete();
        push(1'b0, 96, 0, 1'b0, tl, dk, rc);
        wait_cyc(110);
        check("t2_count", a_q.size(), 96);
        check("t2_drop_after", dk, 64);
        if (a_q.size() >= 32) check("t2_rdy_rise", rc, a_q[31].cyc + 1);
        for (int b = 0; b < 3; b++) check_burst(1'b0, $sformatf("t2_b%0d", b), 32 * b, 32 * b, -1);
        if (a_q.size() >= 96) begin
            check("t2_gap01", (a_q[32].cyc - a_q[31].cyc) >= 33, 1);
            check("t2_gap12", (a_q[64].cyc - a_q[63].cyc) >= 33, 1);
        end
        check("t2_frame_cnt", a_fcnt, 3);

        // Back-to-back bursts, GAP_CYC=0.
        reset_dut(1'b1);
        b_q.delete();
        push(1'b1, 64, 0, 1'b0, tl, dk, rc);
        wait_cyc(40);
        check("t3_count", b_q.size(), 64);
        check_burst(1'b1, "t3_b0", 0, 0, -1);
        check_burst(1'b1, "t3_b1", 32, 32, -1);
        if (b_q.size() >= 33) check("t3_b2b", b_q[32].cyc - b_q[31].cyc, 1);
        check("t3_frame_cnt", b_fcnt, 2);

        // Sparse input, GAP_CYC=0.
        reset_dut(1'b1);
        b_q.delete();
        push(1'b1, 32, 0, 1'b1, tl, dk, rc);
        wait_cyc(40);
        check("t4_count", b_q.size(), 32);
        check_burst(1'b1, "t4", 0, 0, tl + 2);
        check("t4_frame_cnt", b_fcnt, 1);

        // Reset in the middle of a burst, then a fresh frame.
        reset_dut(1'b0);
        push(1'b0, 32, 0, 1'b0, tl, dk, rc);
        cnt = 0; budget = 0;
        while (cnt < 11 && budget < 100) begin
            @(negedge clk);
            if (a_valo === 1'b1) cnt++;
            budget++;
        end
        check("t5_reach_sample10", cnt, 11);
        a_rst = 1'b1;
        @(negedge clk);
        check("t5_val_o", a_valo, 0);
        check("t5_re", a_reo, 0);
        check("t5_im", a_imo, 0);
        check("t5_s_rdy", a_srdy, 1);
        check("t5_frame_cnt", a_fcnt, 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        a_q.delete();
        push(1'b0, 32, 100, 1'b0, tl, dk, rc);
        wait_cyc(40);
        check("t5_count", a_q.size(), 32);
        check_burst(1'b0, "t5", 0, 100, tl + 2);
        check("t5_frame_cnt_after", a_fcnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
